timekeeper_alarm: RTL
=====================

Name: timekeeper_alarm

Overview:
Parametrised successor to the current 50 MHz digital clock top. Keeps HH:MM:SS time in BCD from a prescaled 1 Hz tick. Adds runtime time-set, 12/24-hour display mode, one daily alarm with ring timeout and acknowledge, and a configurable seven-segment polarity. It sits between the board clock/reset and the six 7-segment digit drivers, and replaces the fixed-function clock core.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz; the prescaler divides by this value. Must be ≥2; benches use 10.
RING_SEC, 30, number of 1 Hz ticks the alarm rings before self-clearing. Range 1..255.
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit=0; 0 = lit when bit=1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = timekeeping runs; 0 = prescaler and time frozen, outputs held
mode_12h  in  1  1 = hour digits shown in 12 h format; internal time always 24 h
set_valid  in  1  one-cycle strobe: load set_hh/set_mm/set_ss
set_hh  in  8  BCD hour {tens,ones}, 00..23
set_mm  in  8  BCD minute, 00..59
set_ss  in  8  BCD second, 00..59
alarm_wr  in  1  one-cycle strobe: load alarm_hh/alarm_mm
alarm_hh  in  8  BCD alarm hour, 00..23
alarm_mm  in  8  BCD alarm minute, 00..59
alarm_en  in  1  level: alarm armed
alarm_ack  in  1  one-cycle strobe: stop ringing
tick_1hz  out  1  one-cycle pulse on each second advance
hh_bcd  out  8  internal 24 h hour, BCD
mm_bcd  out  8  minute, BCD
ss_bcd  out  8  second, BCD
pm  out  1  1 when hour ≥12 (valid in both modes)
set_err  out  1  one-cycle pulse: set_valid or alarm_wr rejected as invalid
ringing  out  1  alarm active
seg_h10, seg_h1, seg_m10, seg_m1, seg_s10, seg_s1  out  7 each  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW

Behaviour:
- Reset (async, rst=1): time 00:00:00; prescaler 0; alarm reg 00:00; tick_1hz=0, set_err=0, ringing=0, ring counter 0, pm=0. Segment outputs decode 00:00:00, or 12:00:00 if mode_12h=1 (combinational from the registers).
- Prescaler: counts 0..CLK_HZ-1 while enable=1. At terminal count it wraps to 0, and tick_1hz pulses for that cycle (registered, so it is high the cycle after the terminal count). Time advances on the same edge tick_1hz rises. First tick after reset release: CLK_HZ cycles.
- enable=0: prescaler and time hold; a pending ring counter also holds. set_valid and alarm_wr are still accepted.
- Carry chain: ss 59→00 increments mm; mm 59→00 increments hh; 23:59:59→00:00:00. BCD ones digit 9→0 carries to tens. No binary intermediate.
- set_valid: checked the same cycle. Valid means every ones digit ≤9, hh ≤23, mm/ss ≤59.
  - If valid, time is loaded next edge and the prescaler is cleared to 0. A set strobe coincident with a tick wins; that tick is dropped.
  - If invalid, time is unchanged and set_err pulses next cycle.
- alarm_wr: same validation (hh/mm only). A valid write updates the alarm reg. An invalid write pulses set_err.
- Alarm match: on a tick edge where alarm_en=1 and the new time equals alarm_hh:alarm_mm:00, ringing→1 and the ring counter loads RING_SEC.
  - Each later tick decrements the counter; at 0, ringing→0.
  - alarm_ack or alarm_en=0 clears ringing next edge, and has priority over a simultaneous match.
  - A match triggered by a set_valid load does not ring; only tick advances trigger the alarm.
- 12 h display: display hour = hh if 01..12; hh−12 if 13..23; 12 if hh=00. Leading tens digit shown as 0 (not blanked). pm is independent of mode.
- Seven-segment decode: digits 0..9 use the standard patterns (0=7'b0111111 active-high). Other codes are blank. Output is inverted when SEG_ACTIVE_LOW=1.
- Reset mid-ring: ringing clears immediately (async). Reset mid-count: prescaler clears.

Test Plan:
- Reset/tick, CLK_HZ=10: release rst, run 10 cycles → tick_1hz single pulse, ss_bcd=8'h01; after 600 cycles mm_bcd=8'h01, ss_bcd=8'h00; seg_s1=~7'b0111111 with SEG_ACTIVE_LOW=1.
- Rollover: set 23:59:58, run 2 ticks → 00:00:00, pm 1→0; set 09:59:59, 1 tick → 10:00:00.
- Set validation: set_hh=8'h24 → set_err pulse, time unchanged; set_ss=8'h5A → set_err pulse; set_valid on the same cycle as the terminal count → loaded value held, no increment that cycle, next tick at +CLK_HZ.
- Alarm ring/timeout: alarm 07:30, alarm_en=1, set 07:29:59, 1 tick → ringing=1; RING_SEC=3, 3 more ticks → ringing=0. Repeat, but alarm_ack after 1 tick → ringing=0 next cycle. Set directly to 07:30:00 → no ring.
- 12 h mode: hh=00 → digits "12", pm=0; hh=13 → "01", pm=1; hh=12 → "12", pm=1; toggling mode_12h changes seg_h* only, hh_bcd unchanged.
- enable/reset: enable=0 for 25 cycles → time and prescaler frozen, alarm_wr still accepted. Assert rst mid-ring, with the prescaler at 7 → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/timekeeper_alarm.sv
// rtl/timekeeper_alarm.sv - BCD HH:MM:SS timekeeper with time-set, 12/24 h display,
// daily alarm with ring timeout/acknowledge and seven-segment digit drivers.
module timekeeper_alarm #(
   parameter int CLK_HZ         = 50000000,
   parameter int RING_SEC       = 30,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       mode_12h,
   input  logic       set_valid,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   input  logic       alarm_wr,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_en,
   input  logic       alarm_ack,
   output logic       tick_1hz,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic       pm,
   output logic       set_err,
   output logic       ringing,
   output logic [6:0] seg_h10,
   output logic [6:0] seg_h1,
   output logic [6:0] seg_m10,
   output logic [6:0] seg_m1,
   output logic [6:0] seg_s10,
   output logic [6:0] seg_s1
);

   localparam int             PW    = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  P_TC  = PW'(CLK_HZ - 1);
   localparam logic [7:0]     R_LEN = 8'(RING_SEC);

   // Returns {carry, next} for a 00..59 BCD field.
   function automatic logic [8:0] inc_sexa(input logic [7:0] v);
      if (v == 8'h59)
         return {1'b1, 8'h00};
      else if (v[3:0] == 4'd9)
         return {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      if (v == 8'h23)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // With the ones digit already bounded, a plain compare bounds the tens digit.
   function automatic logic valid_hour(input logic [7:0] v);
      return (v[3:0] <= 4'd9) && (v <= 8'h23);
   endfunction

   function automatic logic valid_sexa(input logic [7:0] v);
      return (v[3:0] <= 4'd9) && (v <= 8'h59);
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   logic [PW-1:0] r_presc;
   logic          r_tick;
   logic [7:0]    r_hh;
   logic [7:0]    r_mm;
   logic [7:0]    r_ss;
   logic          r_err;
   logic [7:0]    r_alm_hh;
   logic [7:0]    r_alm_mm;
   logic          r_ring;
   logic [7:0]    r_ring_cnt;

   logic          w_tc;
   logic          w_set_ok;
   logic          w_alm_ok;
   logic          w_adv;
   logic [8:0]    w_ss_inc;
   logic [8:0]    w_mm_inc;
   logic [7:0]    w_hh_inc;
   logic [7:0]    w_hh_n;
   logic [7:0]    w_mm_n;
   logic [7:0]    w_ss_n;
   logic          w_match;
   logic [4:0]    w_hbin;
   logic [4:0]    w_h12;
   logic [7:0]    w_disp_hh;

   assign w_tc     = enable && (r_presc == P_TC);
   assign w_set_ok = set_valid && valid_hour(set_hh) && valid_sexa(set_mm) && valid_sexa(set_ss);
   assign w_alm_ok = alarm_wr && valid_hour(alarm_hh) && valid_sexa(alarm_mm);
   // A valid set landing on the terminal count swallows that second.
   assign w_adv    = w_tc && !w_set_ok;

   assign w_ss_inc = inc_sexa(r_ss);
   assign w_mm_inc = inc_sexa(r_mm);
   assign w_hh_inc = inc_hour(r_hh);
   assign w_ss_n   = w_ss_inc[7:0];
   assign w_mm_n   = w_ss_inc[8] ? w_mm_inc[7:0] : r_mm;
   assign w_hh_n   = (w_ss_inc[8] && w_mm_inc[8]) ? w_hh_inc : r_hh;

   assign w_match  = w_adv && alarm_en && (w_hh_n == r_alm_hh) &&
                     (w_mm_n == r_alm_mm) && (w_ss_n == 8'h00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= w_adv;
         if (w_set_ok)
            r_presc <= '0;
         else if (enable)
            r_presc <= w_tc ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hh <= 8'h00;
         r_mm <= 8'h00;
         r_ss <= 8'h00;
      end else if (w_set_ok) begin
         r_hh <= set_hh;
         r_mm <= set_mm;
         r_ss <= set_ss;
      end else if (w_adv) begin
         r_hh <= w_hh_n;
         r_mm <= w_mm_n;
         r_ss <= w_ss_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err    <= 1'b0;
         r_alm_hh <= 8'h00;
         r_alm_mm <= 8'h00;
      end else begin
         r_err <= (set_valid && !w_set_ok) || (alarm_wr && !w_alm_ok);
         if (w_alm_ok) begin
            r_alm_hh <= alarm_hh;
            r_alm_mm <= alarm_mm;
         end
      end
   end

   // Acknowledge/disarm outrank a fresh match; the counter only moves on real ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ring     <= 1'b0;
         r_ring_cnt <= 8'd0;
      end else if (alarm_ack || !alarm_en) begin
         r_ring     <= 1'b0;
         r_ring_cnt <= 8'd0;
      end else if (w_match) begin
         r_ring     <= 1'b1;
         r_ring_cnt <= R_LEN;
      end else if (r_ring && w_adv) begin
         if (r_ring_cnt <= 8'd1) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= 8'd0;
         end else begin
            r_ring_cnt <= r_ring_cnt - 8'd1;
         end
      end
   end

   // 12 h hour mapping works on a small binary copy; the time registers stay BCD.
   always_comb begin
      w_hbin    = 5'(r_hh[7:4]) * 5'd10 + 5'(r_hh[3:0]);
      w_h12     = w_hbin;
      w_disp_hh = r_hh;
      if (w_hbin == 5'd0)
         w_h12 = 5'd12;
      else if (w_hbin > 5'd12)
         w_h12 = w_hbin - 5'd12;
      if (mode_12h) begin
         if (w_h12 >= 5'd10)
            w_disp_hh = {4'd1, 4'(w_h12 - 5'd10)};
         else
            w_disp_hh = {4'd0, w_h12[3:0]};
      end
   end

   assign tick_1hz = r_tick;
   assign hh_bcd   = r_hh;
   assign mm_bcd   = r_mm;
   assign ss_bcd   = r_ss;
   assign pm       = (r_hh >= 8'h12);
   assign set_err  = r_err;
   assign ringing  = r_ring;

   assign seg_h10  = seg_decode(w_disp_hh[7:4]);
   assign seg_h1   = seg_decode(w_disp_hh[3:0]);
   assign seg_m10  = seg_decode(r_mm[7:4]);
   assign seg_m1   = seg_decode(r_mm[3:0]);
   assign seg_s10  = seg_decode(r_ss[7:4]);
   assign seg_s1   = seg_decode(r_ss[3:0]);

endmodule
